// File: rtl/branch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the MEM-stage branch controller:
//   - br_mode_e : branch condition select encodings
//   - state_e   : controller state encodings (IDLE / FLUSH)
//   - FCNT_W    : width of the flush down-counter (holds up to 7)
//   - eval_cond : resolves a branch condition from mode and ALU flags
// ---------------------------------------------------------------------------
package branch_pkg;

  localparam int FCNT_W = 3;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLEZ = 3'd2,
    BR_BGTZ = 3'd3,
    BR_BLTZ = 3'd4,
    BR_BGEZ = 3'd5,
    BR_JMP  = 3'd6,
    BR_NOP  = 3'd7
  } br_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Flags are taken literally: zero=1 together with neg=1 is not treated
  // as an error, each mode simply looks at the bits it cares about.
  function automatic logic eval_cond(input logic [2:0] mode,
                                     input logic       zero,
                                     input logic       neg);
    logic c;
    c = 1'b0;
    case (mode)
      BR_BEQ:  c = zero;
      BR_BNE:  c = ~zero;
      BR_BLEZ: c = zero | neg;
      BR_BGTZ: c = ~zero & ~neg;
      BR_BLTZ: c = neg;
      BR_BGEZ: c = ~neg;
      BR_JMP:  c = 1'b1;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// ---------------------------------------------------------------------------
// branch_ctrl_if
// Bundles the branch controller's pipeline-facing signals.
//   membranch   : branch-class instruction present in MEM
//   br_mode     : condition select (see branch_pkg::br_mode_e)
//   zero, neg   : ALU flags for the instruction in MEM
//   cnt_clr     : synchronous clear of the statistics counters
//   pcsrc       : select branch target for next PC (combinational)
//   flush       : squash IF/ID/EX registers (registered)
//   br_count    : saturating count of evaluated branches
//   taken_count : saturating count of taken branches
// Modports: master = pipeline side, slave = branch controller.
// ---------------------------------------------------------------------------
interface branch_ctrl_if #(
  parameter int CNT_WIDTH = 16
);

  logic                 membranch;
  logic [2:0]           br_mode;
  logic                 zero;
  logic                 neg;
  logic                 cnt_clr;
  logic                 pcsrc;
  logic                 flush;
  logic [CNT_WIDTH-1:0] br_count;
  logic [CNT_WIDTH-1:0] taken_count;

  modport master (
    output membranch, br_mode, zero, neg, cnt_clr,
    input  pcsrc, flush, br_count, taken_count
  );

  modport slave (
    input  membranch, br_mode, zero, neg, cnt_clr,
    output pcsrc, flush, br_count, taken_count
  );

endinterface

// File: rtl/branch_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, clears count
//   inc   : count one event this cycle
//   clr   : synchronous clear, wins over inc
//   count : current value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl
// MEM-stage branch resolution. Evaluates the branch condition for the
// instruction in MEM, steers the PC in the same cycle, and then holds flush
// for FLUSH_CYCLES cycles while the wrong-path instructions drain. Also
// keeps saturating statistics of evaluated and taken branches.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : branch_ctrl_if.slave (membranch, br_mode, zero, neg, cnt_clr in;
//           pcsrc, flush, br_count, taken_count out)
// Parameters:
//   FLUSH_CYCLES : 1..7, length of the flush window
//   CNT_WIDTH    : 4..32, width of the statistics counters
// ---------------------------------------------------------------------------
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  branch_ctrl_if.slave bus
);

  localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

  state_e              state;
  state_e              state_next;
  logic [FCNT_W-1:0]   fcnt;
  logic [FCNT_W-1:0]   fcnt_next;
  logic                flush_q;
  logic                cond;
  logic                evaluate;
  logic                taken;
  logic [CNT_WIDTH-1:0] br_cnt;
  logic [CNT_WIDTH-1:0] taken_cnt;

  // Instructions seen during FLUSH are wrong-path, so only IDLE evaluates.
  // Gating with rst_n keeps pcsrc low for the whole reset period.
  assign cond     = eval_cond(bus.br_mode, bus.zero, bus.neg);
  assign evaluate = bus.membranch & (state == ST_IDLE) & rst_n;
  assign taken    = evaluate & cond;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      fcnt    <= '0;
      flush_q <= 1'b0;
    end else begin
      state   <= state_next;
      fcnt    <= fcnt_next;
      flush_q <= (state_next == ST_FLUSH);
    end
  end

  // fcnt counts the remaining flush cycles after the current one, so the
  // window ends on the edge where it reads zero.
  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    case (state)
      ST_IDLE: begin
        if (taken) begin
          state_next = ST_FLUSH;
          fcnt_next  = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (fcnt == '0) begin
          state_next = ST_IDLE;
        end else begin
          fcnt_next = fcnt - 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        fcnt_next  = '0;
      end
    endcase
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_br_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (evaluate),
    .clr   (bus.cnt_clr),
    .count (br_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_taken_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (taken),
    .clr   (bus.cnt_clr),
    .count (taken_cnt)
  );

  assign bus.pcsrc       = taken;
  assign bus.flush       = flush_q;
  assign bus.br_count    = br_cnt;
  assign bus.taken_count = taken_cnt;

endmodule

// File: tb/tb_branch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_ctrl
// Three controller instances share clock and reset:
//   dut_a : defaults (FLUSH_CYCLES=3, CNT_WIDTH=16)
//   dut_b : CNT_WIDTH=4 for saturation
//   dut_c : FLUSH_CYCLES=1 for back-to-back windows
// Each cycle inputs change 1 ns after the rising edge; expected values are
// queued at that point and popped/compared on the following falling edge.
// ---------------------------------------------------------------------------
module tb_branch_ctrl;
  import branch_pkg::*;

  logic clk;
  logic rst_n;

  int errors;
  int checks;
  bit exp_p_q[$];
  bit exp_f_q[$];

  branch_ctrl_if #(.CNT_WIDTH(16)) bus_a ();
  branch_ctrl_if #(.CNT_WIDTH(4))  bus_b ();
  branch_ctrl_if #(.CNT_WIDTH(16)) bus_c ();

  branch_ctrl #(.FLUSH_CYCLES(3), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  branch_ctrl #(.FLUSH_CYCLES(3), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );
  branch_ctrl #(.FLUSH_CYCLES(1), .CNT_WIDTH(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic obs_pcsrc(input int w);
    case (w)
      0:       return bus_a.pcsrc;
      1:       return bus_b.pcsrc;
      default: return bus_c.pcsrc;
    endcase
  endfunction

  function automatic logic obs_flush(input int w);
    case (w)
      0:       return bus_a.flush;
      1:       return bus_b.flush;
      default: return bus_c.flush;
    endcase
  endfunction

  function automatic logic [31:0] obs_br(input int w);
    case (w)
      0:       return 32'(bus_a.br_count);
      1:       return 32'(bus_b.br_count);
      default: return 32'(bus_c.br_count);
    endcase
  endfunction

  function automatic logic [31:0] obs_tk(input int w);
    case (w)
      0:       return 32'(bus_a.taken_count);
      1:       return 32'(bus_b.taken_count);
      default: return 32'(bus_c.taken_count);
    endcase
  endfunction

  // One cycle of stimulus on instance w; the other instances sit idle.
  task automatic drive(input int w, input bit rst, input bit mb,
                       input bit [2:0] mode, input bit z, input bit n,
                       input bit clr);
    @(posedge clk);
    #1;
    rst_n = rst;
    bus_a.membranch = 0; bus_a.br_mode = 0; bus_a.zero = 0; bus_a.neg = 0; bus_a.cnt_clr = 0;
    bus_b.membranch = 0; bus_b.br_mode = 0; bus_b.zero = 0; bus_b.neg = 0; bus_b.cnt_clr = 0;
    bus_c.membranch = 0; bus_c.br_mode = 0; bus_c.zero = 0; bus_c.neg = 0; bus_c.cnt_clr = 0;
    case (w)
      0: begin
        bus_a.membranch = mb; bus_a.br_mode = mode; bus_a.zero = z; bus_a.neg = n; bus_a.cnt_clr = clr;
      end
      1: begin
        bus_b.membranch = mb; bus_b.br_mode = mode; bus_b.zero = z; bus_b.neg = n; bus_b.cnt_clr = clr;
      end
      default: begin
        bus_c.membranch = mb; bus_c.br_mode = mode; bus_c.zero = z; bus_c.neg = n; bus_c.cnt_clr = clr;
      end
    endcase
  endtask

  task automatic test_reset();
    bit ep, ef;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, BR_JMP, 0, 0, 0);
      exp_p_q.push_back(1'b0);
      exp_f_q.push_back(1'b0);
      @(negedge clk);
      ep = exp_p_q.pop_front();
      ef = exp_f_q.pop_front();
      checks++;
      if (obs_pcsrc(0) !== ep) begin
        errors++;
        $display("[TB] FAIL reset_pcsrc[%0d] got=%0b exp=%0b", i, obs_pcsrc(0), ep);
      end
      checks++;
      if (obs_flush(0) !== ef) begin
        errors++;
        $display("[TB] FAIL reset_flush[%0d] got=%0b exp=%0b", i, obs_flush(0), ef);
      end
    end
    for (int w = 0; w < 3; w++) begin
      checks++;
      if (obs_br(w) !== 32'd0 || obs_tk(w) !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset_counts[dut%0d] got=%0d/%0d exp=0/0", w, obs_br(w), obs_tk(w));
      end
    end
    drive(0, 1, 0, BR_BEQ, 0, 0, 0);
  endtask

  task automatic test_beq_truth();
    bit mb_t [8] = '{0, 1, 0, 1, 0, 0, 0, 0};
    bit z_t  [8] = '{0, 0, 1, 1, 0, 0, 0, 0};
    bit p_t  [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    bit f_t  [8] = '{0, 0, 0, 0, 1, 1, 1, 0};
    bit ep, ef;
    drive(0, 1, 0, BR_BEQ, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, mb_t[i], BR_BEQ, z_t[i], 0, 0);
      exp_p_q.push_back(p_t[i]);
      exp_f_q.push_back(f_t[i]);
      @(negedge clk);
      ep = exp_p_q.pop_front();
      ef = exp_f_q.pop_front();
      checks++;
      if (obs_pcsrc(0) !== ep) begin
        errors++;
        $display("[TB] FAIL beq_pcsrc[%0d] got=%0b exp=%0b", i, obs_pcsrc(0), ep);
      end
      checks++;
      if (obs_flush(0) !== ef) begin
        errors++;
        $display("[TB] FAIL beq_flush[%0d] got=%0b exp=%0b", i, obs_flush(0), ef);
      end
    end
    checks++;
    if (obs_br(0) !== 32'd2 || obs_tk(0) !== 32'd1) begin
      errors++;
      $display("[TB] FAIL beq_counts got=%0d/%0d exp=2/1", obs_br(0), obs_tk(0));
    end
  endtask

  task automatic test_mode_sweep();
    bit tk_t [8] = '{0, 1, 1, 0, 1, 0, 1, 0};
    bit ep, ef;
    drive(0, 1, 0, BR_BEQ, 0, 0, 1);
    for (int m = 0; m < 8; m++) begin
      drive(0, 1, 1, 3'(m), 0, 1, 0);
      exp_p_q.push_back(tk_t[m]);
      exp_f_q.push_back(1'b0);
      for (int k = 0; k < 4; k++) begin
        exp_p_q.push_back(1'b0);
        exp_f_q.push_back(tk_t[m] && (k < 3));
      end
      for (int k = 0; k < 5; k++) begin
        if (k > 0) drive(0, 1, 0, BR_BEQ, 0, 0, 0);
        @(negedge clk);
        ep = exp_p_q.pop_front();
        ef = exp_f_q.pop_front();
        checks++;
        if (obs_pcsrc(0) !== ep) begin
          errors++;
          $display("[TB] FAIL sweep_pcsrc[m%0d,c%0d] got=%0b exp=%0b", m, k, obs_pcsrc(0), ep);
        end
        checks++;
        if (obs_flush(0) !== ef) begin
          errors++;
          $display("[TB] FAIL sweep_flush[m%0d,c%0d] got=%0b exp=%0b", m, k, obs_flush(0), ef);
        end
      end
    end
    checks++;
    if (obs_br(0) !== 32'd8 || obs_tk(0) !== 32'd4) begin
      errors++;
      $display("[TB] FAIL sweep_counts got=%0d/%0d exp=8/4", obs_br(0), obs_tk(0));
    end
  endtask

  task automatic test_flush_shadow();
    bit ep, ef;
    drive(0, 1, 0, BR_BEQ, 0, 0, 1);
    for (int c = 0; c < 19; c++) begin
      if (c == 10) begin
        drive(0, 1, 1, BR_JMP, 0, 0, 0);
        exp_p_q.push_back(1'b1); exp_f_q.push_back(1'b0);
      end else if (c >= 11 && c <= 13) begin
        drive(0, 1, 1, BR_BEQ, 1, 0, 0);
        exp_p_q.push_back(1'b0); exp_f_q.push_back(1'b1);
      end else if (c == 14) begin
        drive(0, 1, 1, BR_BEQ, 1, 0, 0);
        exp_p_q.push_back(1'b1); exp_f_q.push_back(1'b0);
      end else begin
        drive(0, 1, 0, BR_BEQ, 0, 0, 0);
        exp_p_q.push_back(1'b0); exp_f_q.push_back(c >= 15 && c <= 17);
      end
      @(negedge clk);
      ep = exp_p_q.pop_front();
      ef = exp_f_q.pop_front();
      checks++;
      if (obs_pcsrc(0) !== ep) begin
        errors++;
        $display("[TB] FAIL shadow_pcsrc[%0d] got=%0b exp=%0b", c, obs_pcsrc(0), ep);
      end
      checks++;
      if (obs_flush(0) !== ef) begin
        errors++;
        $display("[TB] FAIL shadow_flush[%0d] got=%0b exp=%0b", c, obs_flush(0), ef);
      end
      if (c == 13) begin
        checks++;
        if (obs_br(0) !== 32'd1 || obs_tk(0) !== 32'd1) begin
          errors++;
          $display("[TB] FAIL shadow_counts_mid got=%0d/%0d exp=1/1", obs_br(0), obs_tk(0));
        end
      end
    end
    checks++;
    if (obs_br(0) !== 32'd2 || obs_tk(0) !== 32'd2) begin
      errors++;
      $display("[TB] FAIL shadow_counts_end got=%0d/%0d exp=2/2", obs_br(0), obs_tk(0));
    end
  endtask

  task automatic test_saturation();
    bit ep, ef;
    drive(1, 1, 0, BR_NOP, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 1, BR_NOP, 0, 0, 0);
      exp_p_q.push_back(1'b0);
      exp_f_q.push_back(1'b0);
      @(negedge clk);
      ep = exp_p_q.pop_front();
      ef = exp_f_q.pop_front();
      checks++;
      if (obs_pcsrc(1) !== ep || obs_flush(1) !== ef) begin
        errors++;
        $display("[TB] FAIL sat_nop[%0d] got=%0b/%0b exp=%0b/%0b", i, obs_pcsrc(1), obs_flush(1), ep, ef);
      end
    end
    drive(1, 1, 0, BR_NOP, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (obs_br(1) !== 32'd15 || obs_tk(1) !== 32'd0) begin
      errors++;
      $display("[TB] FAIL sat_counts got=%0d/%0d exp=15/0", obs_br(1), obs_tk(1));
    end
    // Clear together with a taken branch: counters clear, window still opens.
    drive(1, 1, 1, BR_JMP, 0, 0, 1);
    @(negedge clk);
    checks++;
    if (obs_pcsrc(1) !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr_pcsrc got=%0b exp=1", obs_pcsrc(1));
    end
    drive(1, 1, 0, BR_NOP, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (obs_br(1) !== 32'd0 || obs_tk(1) !== 32'd0 || obs_flush(1) !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr_priority got=%0d/%0d flush=%0b exp=0/0 flush=1", obs_br(1), obs_tk(1), obs_flush(1));
    end
    drive(1, 1, 0, BR_NOP, 0, 0, 0);
    drive(1, 1, 0, BR_NOP, 0, 0, 0);
    drive(1, 1, 0, BR_NOP, 0, 0, 0);
  endtask

  task automatic test_inconsistent_flags();
    bit [2:0] md_t [6] = '{BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ};
    bit       tk_t [6] = '{1, 0, 1, 0, 1, 0};
    bit ep, ef;
    drive(2, 1, 0, BR_BEQ, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      drive(2, 1, 1, md_t[i], 1, 1, 0);
      exp_p_q.push_back(tk_t[i]); exp_f_q.push_back(1'b0);
      exp_p_q.push_back(1'b0);    exp_f_q.push_back(tk_t[i]);
      for (int k = 0; k < 2; k++) begin
        if (k > 0) drive(2, 1, 0, BR_BEQ, 0, 0, 0);
        @(negedge clk);
        ep = exp_p_q.pop_front();
        ef = exp_f_q.pop_front();
        checks++;
        if (obs_pcsrc(2) !== ep || obs_flush(2) !== ef) begin
          errors++;
          $display("[TB] FAIL zn_mode%0d[c%0d] got=%0b/%0b exp=%0b/%0b", md_t[i], k, obs_pcsrc(2), obs_flush(2), ep, ef);
        end
      end
    end
    checks++;
    if (obs_br(2) !== 32'd6 || obs_tk(2) !== 32'd3) begin
      errors++;
      $display("[TB] FAIL zn_counts got=%0d/%0d exp=6/3", obs_br(2), obs_tk(2));
    end
  endtask

  task automatic test_back_to_back();
    bit ep, ef;
    drive(2, 1, 0, BR_BNE, 0, 0, 1);
    for (int c = 0; c < 10; c++) begin
      drive(2, 1, (c == 5 || c == 7), BR_BNE, 0, 0, 0);
      exp_p_q.push_back(c == 5 || c == 7);
      exp_f_q.push_back(c == 6 || c == 8);
      @(negedge clk);
      ep = exp_p_q.pop_front();
      ef = exp_f_q.pop_front();
      checks++;
      if (obs_pcsrc(2) !== ep) begin
        errors++;
        $display("[TB] FAIL b2b_pcsrc[%0d] got=%0b exp=%0b", c, obs_pcsrc(2), ep);
      end
      checks++;
      if (obs_flush(2) !== ef) begin
        errors++;
        $display("[TB] FAIL b2b_flush[%0d] got=%0b exp=%0b", c, obs_flush(2), ef);
      end
    end
    checks++;
    if (obs_br(2) !== 32'd2 || obs_tk(2) !== 32'd2) begin
      errors++;
      $display("[TB] FAIL b2b_counts got=%0d/%0d exp=2/2", obs_br(2), obs_tk(2));
    end
  endtask

  task automatic test_reset_mid_flush();
    bit rst_t [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    bit mb_t  [10] = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    bit p_t   [10] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    bit f_t   [10] = '{0, 0, 1, 1, 0, 0, 1, 1, 1, 0};
    bit ep, ef;
    for (int c = 0; c < 10; c++) begin
      drive(0, rst_t[c], mb_t[c], BR_JMP, 0, 0, 0);
      exp_p_q.push_back(p_t[c]);
      exp_f_q.push_back(f_t[c]);
      @(negedge clk);
      ep = exp_p_q.pop_front();
      ef = exp_f_q.pop_front();
      checks++;
      if (obs_pcsrc(0) !== ep) begin
        errors++;
        $display("[TB] FAIL rstmid_pcsrc[%0d] got=%0b exp=%0b", c, obs_pcsrc(0), ep);
      end
      checks++;
      if (obs_flush(0) !== ef) begin
        errors++;
        $display("[TB] FAIL rstmid_flush[%0d] got=%0b exp=%0b", c, obs_flush(0), ef);
      end
      if (c == 5 || c == 6) begin
        checks++;
        if (obs_br(0) !== 32'(c - 5) || obs_tk(0) !== 32'(c - 5)) begin
          errors++;
          $display("[TB] FAIL rstmid_counts[%0d] got=%0d/%0d exp=%0d/%0d", c, obs_br(0), obs_tk(0), c - 5, c - 5);
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus_a.membranch = 0; bus_a.br_mode = 0; bus_a.zero = 0; bus_a.neg = 0; bus_a.cnt_clr = 0;
    bus_b.membranch = 0; bus_b.br_mode = 0; bus_b.zero = 0; bus_b.neg = 0; bus_b.cnt_clr = 0;
    bus_c.membranch = 0; bus_c.br_mode = 0; bus_c.zero = 0; bus_c.neg = 0; bus_c.cnt_clr = 0;

    test_reset();
    test_beq_truth();
    test_mode_sweep();
    test_flush_shadow();
    test_saturation();
    test_inconsistent_flags();
    test_back_to_back();
    test_reset_mid_flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 3, range 1..7: number of cycles flush stays high after a taken branch.
REQ-002 Parameter CNT_WIDTH, default 16, range 4..32: width of the statistics counters.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port membranch  input  1  branch-class instruction present in the MEM stage.
REQ-006 Port br_mode  input  3  branch condition select, encoded per REQ-013.
REQ-007 Port zero  input  1  ALU result equals zero.
REQ-008 Port neg  input  1  ALU result sign bit (1 = negative).
REQ-009 Port cnt_clr  input  1  synchronous clear of both statistics counters.
REQ-010 Port pcsrc  output  1  select branch target for the next PC; combinational.
REQ-011 Port flush  output  1  squash the IF/ID/EX pipeline registers; registered.
REQ-012 Ports br_count and taken_count  output  CNT_WIDTH each  saturating counts of evaluated and taken branches.

Function
REQ-013 Mode encodings: BEQ=0 (taken if zero), BNE=1 (!zero), BLEZ=2 (zero|neg), BGTZ=3 (!zero&!neg), BLTZ=4 (neg), BGEZ=5 (!neg), JMP=6 (always), NOP=7 (never).
REQ-014 An evaluation occurs when membranch=1 and the state is IDLE; cond is then computed from br_mode, zero and neg per REQ-013.
REQ-015 pcsrc = 1 in the same cycle as an evaluation whose cond=1; otherwise pcsrc = 0 (zero-latency path).
REQ-016 With br_mode=BEQ and no flush active, pcsrc equals membranch AND zero exactly.
REQ-017 State machine has two states, IDLE and FLUSH; it resets to IDLE.
REQ-018 Transition IDLE->FLUSH on the clock edge after an evaluation with cond=1; the down-counter fcnt loads FLUSH_CYCLES-1.
REQ-019 In FLUSH: flush=1; fcnt decrements each cycle; at fcnt=0, transition FLUSH->IDLE on that edge.
REQ-020 flush is high for exactly FLUSH_CYCLES consecutive cycles, starting the cycle after pcsrc=1.
REQ-021 In FLUSH, membranch is ignored: pcsrc=0, no evaluation, no counter update (wrong-path instruction).
REQ-022 A branch in the first IDLE cycle after FLUSH ends is evaluated normally; back-to-back windows are legal.
REQ-023 br_count increments on every evaluation, including modes NOP and cond=0; taken_count increments on every evaluation with cond=1.
REQ-024 Counters saturate at 2^CNT_WIDTH-1 and do not wrap.
REQ-025 cnt_clr=1 zeroes both counters on the next edge and takes priority over a simultaneous increment; it does not affect state, fcnt or flush.
REQ-026 zero/neg values inconsistent with each other (zero=1 and neg=1) are evaluated literally per REQ-013, without error.

Reset
REQ-027 While rst_n=0 at a rising edge: state=IDLE, fcnt=0, flush=0, br_count=0, taken_count=0.
REQ-028 While rst_n=0, pcsrc is forced to 0 regardless of inputs.
REQ-029 Reset asserted mid-FLUSH aborts the window; flush is 0 from the cycle after the reset edge.

Structure
REQ-030 Package branch_pkg holds the br_mode encodings, the state encodings, and a cond-evaluation function.
REQ-031 Sub-module sat_counter (parameter WIDTH; inputs inc, clr; output count) is instantiated twice, for br_count and taken_count.
REQ-032 Target size is 150-250 lines of RTL, including sat_counter.

Verification
REQ-033 Truth-table scenario, BEQ mode: (membranch,zero) = 00, 10, 01, 11 over 4 IDLE cycles -> pcsrc = 0,0,0,1; then flush=1 for 3 cycles; br_count=2, taken_count=1.
REQ-034 Mode sweep: membranch=1 for each mode 0..7 with zero=0 and neg=1, each spaced by 4 idle cycles -> pcsrc = 0,1,1,0,1,0,1,0; taken_count=4.
REQ-035 Flush shadow: JMP taken at cycle 10, then membranch=1 with BEQ and zero=1 in cycles 11-13 -> pcsrc=0 in cycles 11-13 and counters unchanged; same input at cycle 14 -> pcsrc=1.
REQ-036 Saturation/clear, CNT_WIDTH=4: 20 NOP evaluations -> br_count=15; then cnt_clr together with membranch=1 -> br_count=0.
REQ-037 Reset mid-flush: rst_n=0 in the 2nd flush cycle -> flush=0 and state IDLE next cycle; pcsrc=0 throughout reset.
REQ-038 FLUSH_CYCLES=1: two taken BNE branches in cycles 5 and 7 -> flush high only in cycles 6 and 8.
